// File: rtl/tdc_packet_tx_if.sv
// Word-in / byte-out handshake bundle for tdc_packet_tx.
// The slave side is the packetizer; the master side is its producer plus byte transmitter.
interface tdc_packet_tx_if;
  logic        word_valid;
  logic [31:0] word_data;
  logic        word_ready;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        tx_busy;

  modport master (
    output word_valid, word_data, tx_busy,
    input  word_ready, tx_start, tx_data
  );

  modport slave (
    input  word_valid, word_data, tx_busy,
    output word_ready, tx_start, tx_data
  );
endinterface

// File: rtl/tdc_packet_tx.sv
// Buffers 32-bit TDC words in a small FIFO and sends each word as a 6-byte packet:
// HEADER, four data bytes (LSB first), XOR checksum.
module tdc_packet_tx #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [7:0] HEADER     = 8'hA5
) (
  input  logic          clk,
  input  logic          rst,
  tdc_packet_tx_if.slave link,
  output logic          overflow,
  output logic [15:0]   pkt_count,
  output logic          idle
);

  localparam int          AW   = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, LOAD, START, WAIT_ACK, WAIT_DONE} state_t;

  state_t        state;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW:0]   count;
  logic [31:0]   hold;
  logic [2:0]    idx;
  logic          push;
  logic          pop;
  logic [7:0]    chk;
  logic [7:0]    next_byte;

  assign link.word_ready = (count != FULL);
  assign push            = link.word_valid && link.word_ready;
  assign pop             = (state == IDLE) && (count != '0);
  assign idle            = (state == IDLE) && (count == '0);
  assign chk             = hold[7:0] ^ hold[15:8] ^ hold[23:16] ^ hold[31:24];

  always_comb begin
    next_byte = HEADER;
    case (idx)
      3'd1:    next_byte = hold[7:0];
      3'd2:    next_byte = hold[15:8];
      3'd3:    next_byte = hold[23:16];
      3'd4:    next_byte = hold[31:24];
      3'd5:    next_byte = chk;
      default: next_byte = HEADER;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= link.word_data;
    end
  end

  // A full FIFO refuses the push even when the FSM pops in the same cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
      if (link.word_valid && !link.word_ready) begin
        overflow <= 1'b1;
      end
    end
  end

  // LOAD holds off while the transmitter is still busy, which only happens when a
  // reset abandoned a packet whose last byte is still going out.
  always_ff @(posedge clk) begin
    if (rst) begin
      state         <= IDLE;
      link.tx_start <= 1'b0;
      link.tx_data  <= 8'h00;
      hold          <= 32'h0;
      idx           <= 3'd0;
      pkt_count     <= 16'h0;
    end else begin
      link.tx_start <= 1'b0;
      case (state)
        IDLE: begin
          if (pop) begin
            hold  <= mem[rd_ptr];
            idx   <= 3'd0;
            state <= LOAD;
          end
        end
        LOAD: begin
          if (!link.tx_busy) begin
            link.tx_data  <= next_byte;
            link.tx_start <= 1'b1;
            state         <= START;
          end
        end
        START: begin
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          if (link.tx_busy) begin
            state <= WAIT_DONE;
          end
        end
        WAIT_DONE: begin
          if (!link.tx_busy) begin
            if (idx < 3'd5) begin
              idx   <= idx + 3'd1;
              state <= LOAD;
            end else begin
              pkt_count <= pkt_count + 16'd1;
              state     <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tdc_packet_tx.sv
// Directed bench for tdc_packet_tx with a byte-transmitter model that logs every
// tx_start byte and answers with a 10-cycle busy pulse.
module tb_tdc_packet_tx;

  localparam int BUSY_LEN = 10;

  logic        clk = 1'b0;
  logic        rst;
  logic        overflow;
  logic [15:0] pkt_count;
  logic        idle;

  int          checks = 0;
  int          errors = 0;
  int          start_busy_viol = 0;
  int          start_repeat = 0;
  logic [7:0]  sent [$];
  logic        prev_start = 1'b0;
  logic        auto_busy;
  logic        manual_busy;
  logic        model_busy = 1'b0;
  int          busy_left = 0;

  always #5 clk = ~clk;

  tdc_packet_tx_if link();

  tdc_packet_tx #(.FIFO_DEPTH(4), .HEADER(8'hA5)) dut (
    .clk       (clk),
    .rst       (rst),
    .link      (link),
    .overflow  (overflow),
    .pkt_count (pkt_count),
    .idle      (idle)
  );

  assign link.tx_busy = auto_busy ? model_busy : manual_busy;

  // Transmitter model: busy rises the cycle after an accepted start and lasts BUSY_LEN cycles.
  always @(posedge clk) begin
    if (auto_busy && link.tx_start && !link.tx_busy) begin
      busy_left  <= BUSY_LEN;
      model_busy <= 1'b1;
    end else if (busy_left > 0) begin
      busy_left  <= busy_left - 1;
      model_busy <= (busy_left > 1);
    end
  end

  always @(negedge clk) begin
    if (link.tx_start) begin
      sent.push_back(link.tx_data);
      if (link.tx_busy) start_busy_viol++;
      if (prev_start) start_repeat++;
    end
    prev_start = link.tx_start;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic logic [47:0] pktBytes(input logic [31:0] w);
    logic [7:0] c;
    c = w[7:0] ^ w[15:8] ^ w[23:16] ^ w[31:24];
    return {8'hA5, w[7:0], w[15:8], w[23:16], w[31:24], c};
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic checkBytes(input string tag, input logic [47:0] exp);
    for (int i = 0; i < 6; i++) begin
      logic [7:0] b;
      b = (sent.size() > 0) ? sent.pop_front() : 8'hxx;
      checkOutput($sformatf("%s_byte%0d", tag, i), 32'(b), 32'(exp[47 - 8*i -: 8]));
    end
  endtask

  task automatic checkPacket(input string tag, input logic [31:0] word);
    checkBytes(tag, pktBytes(word));
  endtask

  task automatic checkResetState(input string tag);
    checkOutput({tag, "_tx_start"},   32'(link.tx_start),   32'd0);
    checkOutput({tag, "_tx_data"},    32'(link.tx_data),    32'd0);
    checkOutput({tag, "_overflow"},   32'(overflow),        32'd0);
    checkOutput({tag, "_pkt_count"},  32'(pkt_count),       32'd0);
    checkOutput({tag, "_idle"},       32'(idle),            32'd1);
    checkOutput({tag, "_word_ready"}, 32'(link.word_ready), 32'd1);
  endtask

  // Called at a negedge; offers one word for exactly one rising edge.
  task automatic applyStimulus(input logic [31:0] word);
    link.word_valid = 1'b1;
    link.word_data  = word;
    @(posedge clk);
    @(negedge clk);
    link.word_valid = 1'b0;
  endtask

  task automatic waitIdle(input string tag, input int limit);
    int k;
    k = 0;
    while (!idle && k < limit) begin
      @(negedge clk);
      k++;
    end
    checkOutput(tag, 32'(idle), 32'd1);
  endtask

  logic [31:0] burst [5];

  initial begin
    int k;
    burst[0] = 32'h01020304;
    burst[1] = 32'hA0B0C0D0;
    burst[2] = 32'hDEADBEEF;
    burst[3] = 32'h89ABCDEF;
    burst[4] = 32'h55555555;

    rst             = 1'b1;
    auto_busy       = 1'b1;
    manual_busy     = 1'b0;
    link.word_valid = 1'b0;
    link.word_data  = 32'h0;
    repeat (3) @(negedge clk);
    checkResetState("reset");
    rst = 1'b0;
    @(negedge clk);

    // Single packet and first-byte latency: start visible at the third edge after acceptance.
    applyStimulus(32'h12345678);
    checkOutput("lat_edge1_start", 32'(link.tx_start), 32'd0);
    @(negedge clk);
    checkOutput("lat_edge2_start", 32'(link.tx_start), 32'd0);
    @(negedge clk);
    checkOutput("lat_edge3_start", 32'(link.tx_start), 32'd1);
    checkOutput("lat_edge3_data",  32'(link.tx_data),  32'hA5);
    waitIdle("single_idle", 300);
    checkOutput("single_nbytes", 32'(sent.size()), 32'd6);
    checkBytes("single", 48'hA5_78_56_34_12_08);
    checkOutput("single_pkt_count", 32'(pkt_count), 32'd1);

    // Burst while a packet is in flight: four words fit, the fifth is refused.
    applyStimulus(32'hCAFEF00D);
    k = 0;
    while (!link.tx_busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    checkOutput("burst_busy_seen", 32'(link.tx_busy), 32'd1);
    for (int i = 0; i < 5; i++) begin
      link.word_valid = 1'b1;
      link.word_data  = burst[i];
      checkOutput($sformatf("burst_ready%0d", i), 32'(link.word_ready), (i < 4) ? 32'd1 : 32'd0);
      checkOutput($sformatf("burst_ovf_before%0d", i), 32'(overflow), 32'd0);
      @(posedge clk);
      @(negedge clk);
    end
    link.word_valid = 1'b0;
    checkOutput("burst_overflow", 32'(overflow), 32'd1);
    waitIdle("burst_idle", 3000);
    checkOutput("burst_nbytes", 32'(sent.size()), 32'd30);
    checkPacket("burst_inflight", 32'hCAFEF00D);
    for (int i = 0; i < 4; i++) begin
      checkPacket($sformatf("burst_pkt%0d", i), burst[i]);
    end
    checkOutput("burst_pkt_count", 32'(pkt_count), 32'd6);
    checkOutput("burst_ovf_sticky", 32'(overflow), 32'd1);

    // Checksum boundaries: all-zero and all-one words.
    link.word_valid = 1'b1;
    link.word_data  = 32'h00000000;
    @(posedge clk);
    @(negedge clk);
    link.word_data  = 32'hFFFFFFFF;
    @(posedge clk);
    @(negedge clk);
    link.word_valid = 1'b0;
    waitIdle("edge_idle", 1000);
    checkOutput("edge_nbytes", 32'(sent.size()), 32'd12);
    checkBytes("zero_pkt", 48'hA5_00_00_00_00_00);
    checkBytes("ones_pkt", 48'hA5_FF_FF_FF_FF_00);
    checkOutput("edge_pkt_count", 32'(pkt_count), 32'd8);

    // Reset while waiting for byte 3 to finish.
    applyStimulus(32'h0BADCAFE);
    k = 0;
    while (sent.size() < 4 && k < 200) begin
      @(negedge clk);
      k++;
    end
    k = 0;
    while (!link.tx_busy && k < 20) begin
      @(negedge clk);
      k++;
    end
    @(negedge clk);
    @(negedge clk);
    checkOutput("midrst_nbytes_before", 32'(sent.size()), 32'd4);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    checkResetState("midrst");
    rst = 1'b0;
    repeat (20) @(negedge clk);
    checkOutput("midrst_no_more_start", 32'(sent.size()), 32'd4);
    checkOutput("midrst_idle", 32'(idle), 32'd1);
    sent.delete();
    applyStimulus(32'h13579BDF);
    waitIdle("postrst_idle", 300);
    checkOutput("postrst_nbytes", 32'(sent.size()), 32'd6);
    checkPacket("postrst_pkt", 32'h13579BDF);
    checkOutput("postrst_pkt_count", 32'(pkt_count), 32'd1);

    // Transmitter slow to acknowledge: no repeat start while busy stays low.
    auto_busy   = 1'b0;
    manual_busy = 1'b0;
    applyStimulus(32'h2468ACE0);
    k = 0;
    while (sent.size() < 1 && k < 20) begin
      @(negedge clk);
      k++;
    end
    repeat (20) @(negedge clk);
    checkOutput("noack_nbytes", 32'(sent.size()), 32'd1);
    checkOutput("noack_tx_start", 32'(link.tx_start), 32'd0);
    checkOutput("noack_idle", 32'(idle), 32'd0);
    manual_busy = 1'b1;
    repeat (3) @(negedge clk);
    manual_busy = 1'b0;
    auto_busy   = 1'b1;
    waitIdle("noack_done_idle", 300);
    checkOutput("noack_total_bytes", 32'(sent.size()), 32'd6);
    checkPacket("noack_pkt", 32'h2468ACE0);
    checkOutput("noack_pkt_count", 32'(pkt_count), 32'd2);

    checkOutput("start_while_busy", 32'(start_busy_viol), 32'd0);
    checkOutput("start_repeat", 32'(start_repeat), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
